// File: rtl/arrow_spawner.sv
// arrow_spawner: game-side driver for the arrow sprite.
// Launches one arrow at a time with an LFSR-chosen direction and a speed taken
// from the score. It resolves each arrow from is_hit_in/hit_player_in and keeps
// the score, the lives and the game-over flag. All frame counters advance only
// on the frame tick (hcount_in == 0 && vcount_in == 0).
// Optional feature: define SPAWNER_NO_REPEAT_EN so that no two consecutive
// arrows are launched in the same direction.
module arrow_spawner #(
  parameter int          LIVES         = 3,
  parameter int          GAP_FRAMES    = 30,
  parameter int          FLIGHT_FRAMES = 240,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_in,
  input  logic        is_hit_in,
  input  logic        hit_player_in,
  output logic        arrow_valid_out,
  output logic [1:0]  direction_out,
  output logic [2:0]  speed_out,
  output logic [7:0]  score_out,
  output logic [1:0]  lives_out,
  output logic        game_over_out
);

  localparam int GW = (GAP_FRAMES    < 2) ? 1 : $clog2(GAP_FRAMES + 1);
  localparam int FW = (FLIGHT_FRAMES < 2) ? 1 : $clog2(FLIGHT_FRAMES + 1);

  localparam logic [15:0]   SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [GW-1:0] GAP_LOAD    = GW'(GAP_FRAMES);
  localparam logic [FW-1:0] FLIGHT_LOAD = FW'(FLIGHT_FRAMES);
  localparam logic [1:0]    LIVES_LOAD  = 2'(LIVES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_FLIGHT,
    S_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q;
  logic [GW-1:0] gap_q, gap_d;
  logic [FW-1:0] flight_q, flight_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [1:0]    dir_q, dir_d;
  logic [2:0]    speed_q, speed_d;
  logic          valid_q, valid_d;
  logic          over_q, over_d;
  logic          hit_q;

  logic       tick;
  logic       hit_rise;
  logic       start_game;
  logic       launch;
  logic       lfsr_fb;
  logic [1:0] launch_dir;
  logic [5:0] speed_sum;
  logic [2:0] launch_speed;
  logic [7:0] score_inc;

  assign tick       = (hcount_in == '0) && (vcount_in == '0);
  assign hit_rise   = is_hit_in && !hit_q;
  assign start_game = ((state_q == S_IDLE) || (state_q == S_OVER)) && start_in;
  assign launch     = (state_q == S_GAP) && tick && (gap_q == GW'(1));
  assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Speed grows by one every 8 blocked arrows, capped at 7.
  assign speed_sum    = 6'd1 + {1'b0, score_q[7:3]};
  assign launch_speed = (speed_sum > 6'd7) ? 3'd7 : speed_sum[2:0];
  assign score_inc    = (score_q == 8'hFF) ? score_q : score_q + 8'd1;

`ifdef SPAWNER_NO_REPEAT_EN
  logic first_q;

  // direction_out still holds the previous arrow's direction, so it serves as
  // the reference; first_q frees the first arrow of each game.
  assign launch_dir = (!first_q && (lfsr_q[1:0] == dir_q)) ? dir_q + 2'd1 : lfsr_q[1:0];

  // Marks the first launch after a game start as unconstrained.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b1;
    end else if (start_game) begin
      first_q <= 1'b1;
    end else if (launch) begin
      first_q <= 1'b0;
    end
  end
`else
  assign launch_dir = lfsr_q[1:0];
`endif

  // Free-running Fibonacci LFSR and the is_hit_in edge register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      hit_q  <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      hit_q  <= is_hit_in;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      flight_q <= '0;
      score_q  <= '0;
      lives_q  <= '0;
      dir_q    <= '0;
      speed_q  <= '0;
      valid_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      flight_q <= flight_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      valid_q  <= valid_d;
      over_q   <= over_d;
    end
  end

  // Next-state, counter and output decisions.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    flight_d = flight_q;
    score_d  = score_q;
    lives_d  = lives_q;
    dir_d    = dir_q;
    speed_d  = speed_q;
    valid_d  = valid_q;
    over_d   = over_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_game) begin
          state_d = S_GAP;
          lives_d = LIVES_LOAD;
          score_d = '0;
          gap_d   = GAP_LOAD;
          valid_d = 1'b0;
          over_d  = 1'b0;
        end
      end

      S_GAP: begin
        valid_d = 1'b0;
        if (launch) begin
          state_d  = S_FLIGHT;
          dir_d    = launch_dir;
          speed_d  = launch_speed;
          flight_d = FLIGHT_LOAD;
          valid_d  = 1'b1;
        end else if (tick) begin
          gap_d = gap_q - GW'(1);
        end
      end

      S_FLIGHT: begin
        valid_d = 1'b1;
        // Priority: a player hit, then a block, then the flight timeout.
        if (hit_player_in) begin
          lives_d = lives_q - 2'd1;
          valid_d = 1'b0;
          if (lives_q == 2'd1) begin
            state_d = S_OVER;
            over_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end
        end else if (hit_rise) begin
          score_d = score_inc;
          valid_d = 1'b0;
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else if (tick) begin
          if (flight_q == FW'(1)) begin
            valid_d = 1'b0;
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            flight_d = flight_q - FW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign arrow_valid_out = valid_q;
  assign direction_out   = dir_q;
  assign speed_out       = speed_q;
  assign score_out       = score_q;
  assign lives_out       = lives_q;
  assign game_over_out   = over_q;

endmodule

// File: tb/tb_arrow_spawner.sv
// Directed bench for arrow_spawner (GAP_FRAMES=2, FLIGHT_FRAMES=4, LIVES=3).
module tb_arrow_spawner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = 11'd100;
  logic [9:0]  vcount_in = 10'd50;
  logic        start_in = 1'b0;
  logic        is_hit_in = 1'b0;
  logic        hit_player_in = 1'b0;
  logic        arrow_valid_out;
  logic [1:0]  direction_out;
  logic [2:0]  speed_out;
  logic [7:0]  score_out;
  logic [1:0]  lives_out;
  logic        game_over_out;

  always #5 clk = ~clk;

  arrow_spawner #(
    .LIVES(3),
    .GAP_FRAMES(2),
    .FLIGHT_FRAMES(4),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .start_in(start_in),
    .is_hit_in(is_hit_in),
    .hit_player_in(hit_player_in),
    .arrow_valid_out(arrow_valid_out),
    .direction_out(direction_out),
    .speed_out(speed_out),
    .score_out(score_out),
    .lives_out(lives_out),
    .game_over_out(game_over_out)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  logic [1:0] m_prev  = 2'd0;
  bit         m_first = 1'b1;
  int         m_score = 0;
  int         m_lives = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_tick(input bit t);
    hcount_in = t ? 11'd0 : 11'd100;
    vcount_in = t ? 10'd0 : 10'd50;
  endtask

  // Direction the next launch should carry; call before the launching edge.
  task automatic predict_dir(output logic [1:0] d);
`ifdef SPAWNER_NO_REPEAT_EN
    d = (!m_first && (m_lfsr[1:0] == m_prev)) ? m_prev + 2'd1 : m_lfsr[1:0];
`else
    d = m_lfsr[1:0];
`endif
    m_first = 1'b0;
  endtask

  function automatic int exp_speed(input int s);
    int e;
    e = 1 + s / 8;
    return (e > 7) ? 7 : e;
  endfunction

  // From GAP with a fresh gap count: two ticks, arrow launched on the second.
  task automatic launch_arrow();
    logic [1:0] d;
    logic [1:0] prev;
    bit         first;
    set_tick(1'b1);
    step();
    check("gap_valid_low", arrow_valid_out, 0);
    first = m_first;
    prev  = m_prev;
    predict_dir(d);
    step();
    set_tick(1'b0);
    check("launch_valid", arrow_valid_out, 1);
    check("launch_dir", direction_out, d);
    check("launch_speed", speed_out, exp_speed(m_score));
`ifdef SPAWNER_NO_REPEAT_EN
    if (!first) check("no_repeat", int'(direction_out != prev), 1);
`endif
    m_prev = d;
  endtask

  task automatic block_arrow();
    is_hit_in     = 1'b1;
    hit_player_in = 1'b0;
    step();
    if (m_score < 255) m_score++;
    check("block_valid", arrow_valid_out, 0);
    check("block_score", score_out, m_score);
    check("block_lives", lives_out, m_lives);
    is_hit_in = 1'b0;
  endtask

  typedef struct {
    bit st, hit, hp, tk, ng, ln;
    bit v;
    int s, l;
    bit o;
    int sp;
  } vec_t;

  vec_t tv[33];

  task automatic setv(input int i, input bit st, hit, hp, tk, ng, ln,
                      input bit v, input int s, l, input bit o, input int sp);
    tv[i].st = st; tv[i].hit = hit; tv[i].hp = hp; tv[i].tk = tk;
    tv[i].ng = ng; tv[i].ln = ln;
    tv[i].v = v; tv[i].s = s; tv[i].l = l; tv[i].o = o; tv[i].sp = sp;
  endtask

  initial begin
    logic [1:0] d;

    //        i  st hit hp tk ng ln  v  s  l  o  sp
    setv( 0, 1, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0); // start -> GAP
    setv( 1, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0); // tick 1
    setv( 2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0); // no tick
    setv( 3, 0, 0, 0, 1, 0, 1, 1, 0, 3, 0, 1); // tick 2 -> launch
    setv( 4, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 1);
    setv( 5, 0, 1, 0, 0, 0, 0, 0, 1, 3, 0, 1); // block
    setv( 6, 0, 1, 0, 0, 0, 0, 0, 1, 3, 0, 1); // is_hit held: no effect
    setv( 7, 0, 0, 0, 1, 0, 0, 0, 1, 3, 0, 1);
    setv( 8, 0, 0, 0, 1, 0, 1, 1, 1, 3, 0, 1);
    setv( 9, 0, 1, 1, 0, 0, 0, 0, 1, 2, 0, 1); // hit player
    setv(10, 0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 1);
    setv(11, 0, 0, 0, 1, 0, 1, 1, 1, 2, 0, 1);
    setv(12, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1); // hit_player alone
    setv(13, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1);
    setv(14, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 1);
    setv(15, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1); // start ignored in FLIGHT
    setv(16, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1);
    setv(17, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1);
    setv(18, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1);
    setv(19, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1); // 4th tick: timeout
    setv(20, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1);
    setv(21, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 1);
    setv(22, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1);
    setv(23, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1);
    setv(24, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 1);
    setv(25, 0, 1, 0, 1, 0, 0, 0, 2, 1, 0, 1); // block on 4th tick wins
    setv(26, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0, 1);
    setv(27, 0, 0, 0, 1, 0, 1, 1, 2, 1, 0, 1);
    setv(28, 0, 1, 1, 0, 0, 0, 0, 2, 0, 1, 1); // last life lost -> OVER
    setv(29, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1, 1);
    setv(30, 1, 0, 0, 0, 1, 0, 0, 0, 3, 0, 1); // restart from OVER
    setv(31, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 1);
    setv(32, 0, 0, 0, 1, 0, 1, 1, 0, 3, 0, 1);

    // Reset state
    step();
    step();
    check("rst_valid", arrow_valid_out, 0);
    check("rst_dir", direction_out, 0);
    check("rst_speed", speed_out, 0);
    check("rst_score", score_out, 0);
    check("rst_lives", lives_out, 0);
    check("rst_over", game_over_out, 0);
    rst = 1'b0;
    step();
    check("idle_valid", arrow_valid_out, 0);

    // Table-driven game sequence
    for (int i = 0; i < 33; i++) begin
      start_in      = tv[i].st;
      is_hit_in     = tv[i].hit;
      hit_player_in = tv[i].hp;
      set_tick(tv[i].tk);
      if (tv[i].ng) m_first = 1'b1;
      if (tv[i].ln) predict_dir(d);
      step();
      check($sformatf("vec%0d_valid", i), arrow_valid_out, tv[i].v);
      check($sformatf("vec%0d_score", i), score_out, tv[i].s);
      check($sformatf("vec%0d_lives", i), lives_out, tv[i].l);
      check($sformatf("vec%0d_over", i), game_over_out, tv[i].o);
      check($sformatf("vec%0d_speed", i), speed_out, tv[i].sp);
      if (tv[i].ln) begin
        check($sformatf("vec%0d_dir", i), direction_out, d);
        m_prev = d;
      end
    end
    start_in = 1'b0; is_hit_in = 1'b0; hit_player_in = 1'b0; set_tick(1'b0);
    m_score = 0;
    m_lives = 3;

    // Reach score 5, launch, then reset mid-flight
    block_arrow();
    for (int i = 0; i < 4; i++) begin
      launch_arrow();
      block_arrow();
    end
    launch_arrow();
    check("pre_rst_score", score_out, 5);
    rst      = 1'b1;
    start_in = 1'b1;
    step();
    check("midrst_valid", arrow_valid_out, 0);
    check("midrst_dir", direction_out, 0);
    check("midrst_speed", speed_out, 0);
    check("midrst_score", score_out, 0);
    check("midrst_lives", lives_out, 0);
    check("midrst_over", game_over_out, 0);
    step();
    step();
    check("rst_hold_lives", lives_out, 0);
    check("rst_hold_valid", arrow_valid_out, 0);
    rst      = 1'b0;
    start_in = 1'b0;
    set_tick(1'b1);
    step();
    step();
    set_tick(1'b0);
    check("post_rst_idle_valid", arrow_valid_out, 0);
    check("post_rst_idle_lives", lives_out, 0);
    start_in = 1'b1;
    m_first  = 1'b1;
    m_score  = 0;
    m_lives  = 3;
    step();
    start_in = 1'b0;
    check("restart_lives", lives_out, 3);
    check("restart_score", score_out, 0);

    // Climb the score to saturation; speed follows score[7:3]
    for (int i = 0; i < 256; i++) begin
      launch_arrow();
      if (m_score == 16) check("speed_at_16", speed_out, 3);
      if (m_score == 255) check("speed_at_255", speed_out, 7);
      block_arrow();
    end
    check("score_saturated", score_out, 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
